branch_offset_encoder: RTL and testbench



---
 rtl/branch_offset_encoder_if.sv | 27 ++
 rtl/branch_offset_encoder.sv | 79 +++++++
 tb/tb_branch_offset_encoder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_offset_encoder_if.sv
// Request/result bundle for branch_offset_encoder: target-address source on the
// master side, encoder on the slave side.
interface branch_offset_encoder_if #(
  parameter int OFF_W = 16,
  parameter int ERR_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      pc;
  logic [31:0]      target;
  logic             out_valid;
  logic             out_ready;
  logic [OFF_W-1:0] offset;
  logic             fits;
  logic             aligned;
  logic [ERR_W-1:0] err_count;

  modport master (
    output in_valid, pc, target, out_ready,
    input  in_ready, out_valid, offset, fits, aligned, err_count
  );

  modport slave (
    input  in_valid, pc, target, out_ready,
    output in_ready, out_valid, offset, fits, aligned, err_count
  );
endinterface

// File: rtl/branch_offset_encoder.sv
// Two-stage valid/ready pipeline encoding (pc, target) into a signed word
// offset with range/alignment flags and a saturating error counter.
module branch_offset_encoder #(
  parameter int OFF_W = 16,
  parameter int ERR_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  branch_offset_encoder_if.slave bus
);
  localparam int HI_W = 31 - OFF_W;

  logic             s1_valid;
  logic [31:0]      s1_diff;
  logic             s2_valid;
  logic [OFF_W-1:0] s2_offset;
  logic             s2_fits;
  logic             s2_aligned;
  logic [ERR_W-1:0] err_q;

  logic             s2_adv;
  logic             s1_adv;
  logic             accept;
  logic             take;
  logic [29:0]      w;
  logic [HI_W-1:0]  w_hi;
  logic             fits_c;
  logic             aligned_c;

  always_comb begin
    s2_adv    = !s2_valid || bus.out_ready;
    s1_adv    = !s1_valid || s2_adv;
    accept    = bus.in_valid && !reset && s1_adv;
    take      = s2_valid && bus.out_ready;
    // diff >>> 2 keeps the sign bit in w[29], so the word offset is just diff[31:2]
    w         = s1_diff[31:2];
    w_hi      = w[29:OFF_W-1];
    fits_c    = (&w_hi) || !(|w_hi);
    aligned_c = (s1_diff[1:0] == 2'b00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_diff    <= '0;
      s2_valid   <= 1'b0;
      s2_offset  <= '0;
      s2_fits    <= 1'b0;
      s2_aligned <= 1'b0;
      err_q      <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) begin
          s1_diff <= bus.target - (bus.pc + 32'd4);
        end
      end
      // Result registers only move when stage 2 can hand off, holding them under stall
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_offset  <= w[OFF_W-1:0];
          s2_fits    <= fits_c;
          s2_aligned <= aligned_c;
        end
      end
      if (take && !(s2_fits && s2_aligned) && (err_q != '1)) begin
        err_q <= err_q + 1'b1;
      end
    end
  end

  assign bus.in_ready  = !reset && s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.offset    = s2_offset;
  assign bus.fits      = s2_fits;
  assign bus.aligned   = s2_aligned;
  assign bus.err_count = err_q;
endmodule

// File: tb/tb_branch_offset_encoder.sv
// Self-checking bench for branch_offset_encoder: vector table, directed
// backpressure/reset/saturation sequences and randomized scoreboard checks.
module tb_branch_offset_encoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  branch_offset_encoder_if #(.OFF_W(16), .ERR_W(8)) bus ();

  branch_offset_encoder #(.OFF_W(16), .ERR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
    logic [15:0] offset;
    logic        fits;
    logic        aligned;
  } exp_t;

  int tests = 0;
  int fails = 0;

  exp_t q[$];
  int   model_err = 0;
  logic stall_prev = 1'b0;
  logic [15:0] held_off;
  logic held_fits, held_aligned;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: floor division of the signed byte distance by 4
  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] tgt);
    exp_t   e;
    longint sd;
    longint wd;
    logic [31:0] diff;
    diff = tgt - pc - 32'd4;
    sd = longint'($signed(diff));
    if (sd >= 0) wd = sd / 4;
    else         wd = -((-sd + 3) / 4);
    e.pc      = pc;
    e.target  = tgt;
    e.aligned = ((sd % 4) == 0);
    e.fits    = (wd >= -32768) && (wd <= 32767);
    e.offset  = 16'(wd);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] re;
    chk("err_count", 32'(bus.err_count), 32'(model_err));
    if (stall_prev) begin
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_offset", 32'(bus.offset), 32'(held_off));
      chk("hold_flags", {30'd0, bus.fits, bus.aligned}, {30'd0, held_fits, held_aligned});
    end
    if (reset) begin
      q.delete();
      model_err  = 0;
      stall_prev = 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_result: got offset %h expected no result at %0t", bus.offset, $time);
        end else begin
          tests--;
          e = q.pop_front();
          chk("sb_offset", 32'(bus.offset), 32'(e.offset));
          chk("sb_flags", {30'd0, bus.fits, bus.aligned}, {30'd0, e.fits, e.aligned});
          if (e.fits && e.aligned) begin
            re = e.pc + 32'd4 + {{14{bus.offset[15]}}, bus.offset, 2'b00};
            chk("reexpand", re, e.target);
          end
          if (!(e.fits && e.aligned) && model_err < 255) model_err++;
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model(bus.pc, bus.target));
      stall_prev   = bus.out_valid && !bus.out_ready;
      held_off     = bus.offset;
      held_fits    = bus.fits;
      held_aligned = bus.aligned;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  exp_t vecs[6];
  logic [31:0] bp_tgt[3];
  logic [15:0] bp_off[3];

  initial begin
    int cnt;
    int idx;
    int acc;
    logic a;

    vecs[0] = '{32'h0040_0000, 32'h0040_0010, 16'h0003, 1'b1, 1'b1};
    vecs[1] = '{32'h0040_0020, 32'h0040_0000, 16'hFFF7, 1'b1, 1'b1};
    vecs[2] = '{32'h0000_0000, 32'h0002_0000, 16'h7FFF, 1'b1, 1'b1};
    vecs[3] = '{32'h0000_0000, 32'h0002_0004, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{32'h0002_0000, 32'h0000_0004, 16'h8000, 1'b1, 1'b1};
    vecs[5] = '{32'h0000_0000, 32'h0000_0006, 16'h0000, 1'b1, 1'b0};
    bp_tgt = '{32'h104, 32'h208, 32'h30C};
    bp_off = '{16'h0040, 16'h0081, 16'h00C2};

    // Reset: a request presented during reset must be ignored
    bus.in_valid  = 1'b1;
    bus.pc        = 32'h0;
    bus.target    = 32'h10;
    bus.out_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_offset", 32'(bus.offset), 32'd0);
    chk("rst_flags", {30'd0, bus.fits, bus.aligned}, 32'd0);
    chk("rst_err", 32'(bus.err_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

    // Table vectors, one at a time, checking the two-edge latency as well
    for (int i = 0; i < 6; i++) begin
      bus.pc       = vecs[i].pc;
      bus.target   = vecs[i].target;
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("vec_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      cnt = 0;
      while (!bus.out_valid && cnt < 8) begin
        tick();
        cnt++;
      end
      chk("vec_latency", 32'(cnt), 32'd1);
      chk("vec_offset", 32'(bus.offset), 32'(vecs[i].offset));
      chk("vec_fits", 32'(bus.fits), 32'(vecs[i].fits));
      chk("vec_aligned", 32'(bus.aligned), 32'(vecs[i].aligned));
    end
    tick();
    tick();
    chk("vec_err_count", 32'(bus.err_count), 32'd2);

    // Backpressure: three requests against a stalled consumer
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = (idx < 3);
      if (idx < 3) begin
        bus.pc     = 32'h0;
        bus.target = bp_tgt[idx];
      end
      @(negedge clk);
      a = bus.in_ready && bus.in_valid;
      tick();
      if (a) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd2);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_head", 32'(bus.offset), 32'(bp_off[0]));
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_drain_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_drain_offset", 32'(bus.offset), 32'(bp_off[k]));
      a = bus.in_ready && bus.in_valid;
      tick();
      if (a) idx++;
      if (idx == 3) bus.in_valid = 1'b0;
    end
    chk("bp_all_accepted", 32'(idx), 32'd3);
    tick();
    chk("bp_empty", 32'(bus.out_valid), 32'd0);

    // Reset with two entries in flight
    bus.out_ready = 1'b0;
    bus.pc        = 32'h0;
    bus.target    = 32'h6;
    bus.in_valid  = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("mid_full", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.out_valid) cnt++;
    end
    chk("mid_no_stale", 32'(cnt), 32'd0);
    chk("mid_err_clear", 32'(bus.err_count), 32'd0);

    // Saturation: 300 misaligned results streamed back to back
    bus.pc       = 32'h0;
    bus.target   = 32'h6;
    bus.in_valid = 1'b1;
    acc = 0;
    cnt = 0;
    while (acc < 300 && cnt < 1000) begin
      @(negedge clk);
      if (bus.in_ready) acc++;
      tick();
      cnt++;
    end
    bus.in_valid = 1'b0;
    chk("sat_accepts", 32'(acc), 32'd300);
    chk("sat_throughput", 32'(cnt), 32'd300);
    for (int k = 0; k < 4; k++) tick();
    chk("sat_err_count", 32'(bus.err_count), 32'd255);

    // Randomized traffic against the scoreboard
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.pc        = $urandom;
      case ($urandom_range(0, 2))
        0: bus.target = $urandom;
        1: bus.target = bus.pc + 32'd4 + 32'($urandom_range(0, 32'h7FFFF)) - 32'h40000;
        default: bus.target = bus.pc + 32'd4 + 32'($urandom_range(0, 16)) - 32'd8;
      endcase
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("rand_drained", 32'(q.size()), 32'd0);
    chk("rand_idle", 32'(bus.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
